// File: rtl/dmux_scan_driver_if.sv
// -----------------------------------------------------------------------------
// dmux_scan_driver_if
//   Bundles the upstream word handshake and the demux drive lines of
//   dmux_scan_driver.
//
//   Signals:
//     in_valid  upstream word available
//     in_data   4-bit word, bit k goes to channel k
//     in_ready  driver can accept a word this cycle
//     sel       demux select (channel index)
//     d         demux data bit
//     stb       sel/d valid for capture this cycle
//     busy      scan in progress
//     done      one-cycle pulse on the last channel of a word
//
//   Modports:
//     master  upstream side (drives in_valid/in_data, observes the rest)
//     slave   driver side (dmux_scan_driver)
// -----------------------------------------------------------------------------
interface dmux_scan_driver_if;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [1:0] sel;
  logic       d;
  logic       stb;
  logic       busy;
  logic       done;

  modport master (
    output in_valid, in_data,
    input  in_ready, sel, d, stb, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, sel, d, stb, busy, done
  );
endinterface

// File: rtl/dmux_scan_driver.sv
// -----------------------------------------------------------------------------
// dmux_scan_driver
//   Upstream feeder for a 1-to-4 demultiplexer. Accepts a 4-bit word over a
//   valid/ready handshake and plays it out one bit per channel in order 0..3,
//   driving the demux select (sel) and data (d) lines with a capture strobe
//   (stb). Back-to-back words stream with no idle bubble: the next word is
//   accepted in the final cycle of channel 3.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    dmux_scan_driver_if.slave (in_valid, in_data, in_ready,
//            sel, d, stb, busy, done)
//
//   Parameter:
//     IDLE_D  value driven on d while no word is being scanned
//
//   Configuration macro:
//     DMUX_SCAN_HOLD_EN  when defined, each channel period is two cycles: a
//                        settle cycle (ph=0, stb=0) followed by a capture
//                        cycle (ph=1, stb=1), with sel/d driven in both.
//                        When undefined, each channel lasts one cycle.
//
//   All outputs are decoded from registers only; in_ready depends on the
//   state registers alone, never on in_valid/in_data.
// -----------------------------------------------------------------------------
module dmux_scan_driver #(
  parameter logic IDLE_D = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dmux_scan_driver_if.slave    bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0] state_r, state_s;
  logic [1:0] ch_r, ch_s;
  logic [3:0] wreg_r, wreg_s;
  logic       period_end_s;   // last cycle of the current channel period
  logic       ready_s;
  logic       accept_s;

`ifdef DMUX_SCAN_HOLD_EN
  logic       ph_r, ph_s;

  // With hold, a channel period ends on its capture (second) cycle.
  assign period_end_s = ph_r;
`else
  // Without hold, every scan cycle is the end of its channel period.
  assign period_end_s = 1'b1;
`endif

  // Ready in idle, or in the final cycle of channel 3 so words chain seamlessly.
  always_comb begin
    ready_s = 1'b0;
    if (state_r == S_IDLE) begin
      ready_s = 1'b1;
    end else begin
      ready_s = (ch_r == 2'd3) && period_end_s;
    end
  end

  assign accept_s = bus.in_valid && ready_s;

  // Next-state logic for the scan sequencer.
  always_comb begin
    state_s = state_r;
    ch_s    = ch_r;
    wreg_s  = wreg_r;
`ifdef DMUX_SCAN_HOLD_EN
    ph_s    = ph_r;
`endif
    case (state_r)
      S_IDLE: begin
`ifdef DMUX_SCAN_HOLD_EN
        ph_s = 1'b0;
`endif
        if (accept_s) begin
          state_s = S_SCAN;
          ch_s    = 2'd0;
          wreg_s  = bus.in_data;
        end else begin
          state_s = S_IDLE;
          ch_s    = 2'd0;
        end
      end
      S_SCAN: begin
`ifdef DMUX_SCAN_HOLD_EN
        // Settle/capture alternate; the end of a period always returns to 0,
        // which is also the correct phase for a freshly reloaded word.
        ph_s = ~ph_r;
`endif
        if (period_end_s) begin
          if (ch_r == 2'd3) begin
            if (accept_s) begin
              state_s = S_SCAN;
              ch_s    = 2'd0;
              wreg_s  = bus.in_data;
            end else begin
              state_s = S_IDLE;
              ch_s    = 2'd0;
            end
          end else begin
            ch_s = ch_r + 2'd1;
          end
        end else begin
          ch_s = ch_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        ch_s    = 2'd0;
        wreg_s  = 4'd0;
`ifdef DMUX_SCAN_HOLD_EN
        ph_s    = 1'b0;
`endif
      end
    endcase
  end

  // State registers; reset discards any word in flight immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      ch_r    <= 2'd0;
      wreg_r  <= 4'd0;
`ifdef DMUX_SCAN_HOLD_EN
      ph_r    <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      ch_r    <= ch_s;
      wreg_r  <= wreg_s;
`ifdef DMUX_SCAN_HOLD_EN
      ph_r    <= ph_s;
`endif
    end
  end

  // Output decode from registers only, so sel/d move only on clock edges.
  always_comb begin
    bus.in_ready = ready_s;
    bus.sel      = 2'd0;
    bus.d        = IDLE_D;
    bus.stb      = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    if (state_r == S_SCAN) begin
      bus.sel  = ch_r;
      bus.d    = wreg_r[ch_r];
      bus.stb  = period_end_s;
      bus.busy = 1'b1;
      bus.done = (ch_r == 2'd3) && period_end_s;
    end else begin
      bus.sel  = 2'd0;
      bus.d    = IDLE_D;
    end
  end

endmodule

// File: tb/tb_dmux_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_dmux_scan_driver
//   Scoreboard bench for dmux_scan_driver. Each accepted word pushes its four
//   expected (sel, d, done) strobes into a queue; the monitor pops one entry per
//   observed strobe. A cycle counter model predicts in_ready, busy and stb.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmux_scan_driver;

`ifdef DMUX_SCAN_HOLD_EN
  localparam int P = 2;
`else
  localparam int P = 1;
`endif
  localparam logic IDLE_D = 1'b0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  dmux_scan_driver_if bus ();

  dmux_scan_driver #(.IDLE_D(IDLE_D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int         n_checks = 0;
  int         n_fails  = 0;
  int         left     = 0;   // model: scan cycles remaining for the current word
  int         acc_cnt  = 0;   // model: words accepted so far
  logic [3:0] exp_q[$];       // entries {sel[1:0], d, done}

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor and model, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    logic [3:0] e;
    logic       exp_rdy;
    logic       exp_stb;
    logic [1:0] kk;
    if (!rst_n) begin
      exp_q.delete();
      left = 0;
    end else begin
      exp_rdy = (left <= 1);
      exp_stb = (left > 0) && ((P == 1) || ((left % 2) == 1));
      check("in_ready", bus.in_ready, exp_rdy);
      check("busy", bus.busy, left > 0);
      check("stb", bus.stb, exp_stb);
      if (left == 0) begin
        check("idle_sel", bus.sel, 2'd0);
        check("idle_d", bus.d, IDLE_D);
        check("idle_done", bus.done, 1'b0);
      end else begin
        check("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          if (exp_stb) begin
            e = exp_q.pop_front();
            check("sel", bus.sel, e[3:2]);
            check("d", bus.d, e[1]);
            check("done", bus.done, e[0]);
          end else begin
            e = exp_q[0];
            check("settle_sel", bus.sel, e[3:2]);
            check("settle_d", bus.d, e[1]);
            check("settle_done", bus.done, 1'b0);
          end
        end
      end
      if (left > 0) left--;
      if (bus.in_valid && exp_rdy) begin
        left = 4 * P;
        acc_cnt++;
        for (int k = 0; k < 4; k++) begin
          kk = k[1:0];
          exp_q.push_back({kk, bus.in_data[k], (k == 3)});
        end
      end
    end
  end

  // Offer a word until the model sees it accepted; optionally drop valid after.
  task automatic send(input logic [3:0] w, input bit drop);
    int c0;
    int n;
    c0 = acc_cnt;
    n  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    do begin
      @(posedge clk); #1;
      n++;
    end while (acc_cnt == c0 && n < 50);
    check("accept_timeout", acc_cnt != c0, 1'b1);
    if (drop) bus.in_valid = 1'b0;
  endtask

  // Wait until every expected strobe has been observed, bounded.
  task automatic drain();
    int n;
    n = 0;
    while ((left != 0 || exp_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", n < 100, 1'b1);
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 4'd0;
    rst_n        = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_sel", bus.sel, 2'd0);
    check("rst_d", bus.d, IDLE_D);
    check("rst_stb", bus.stb, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle with in_valid low; data lines wiggle but must be ignored.
    for (int i = 0; i < 10; i++) begin
      bus.in_data = 4'($urandom);
      @(posedge clk); #1;
    end

    // Single word.
    send(4'b1010, 1'b1);
    drain();

    // Back-to-back words with in_valid held high.
    send(4'b0001, 1'b0);
    send(4'b1110, 1'b1);
    drain();

    // Inputs toggled during the scan must not disturb it.
    send(4'b0110, 1'b1);
    for (int i = 0; i < 4 * P - 1; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = 4'($urandom);
      @(posedge clk); #1;
    end
    send(4'b1001, 1'b1);
    drain();

    // Asynchronous reset during channel 2.
    send(4'b1111, 1'b1);
    repeat (2 * P) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", bus.in_ready, 1'b1);
    check("arst_sel", bus.sel, 2'd0);
    check("arst_d", bus.d, IDLE_D);
    check("arst_stb", bus.stb, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send(4'b0011, 1'b1);
    drain();

    // Random words with random gaps.
    for (int i = 0; i < 8; i++) begin
      send(4'($urandom), 1'($urandom_range(0, 1)));
      if (!bus.in_valid) begin
        repeat ($urandom_range(0, 5)) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    drain();

    check("final_queue", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
